fetch_issue: RTL and testbench
==============================

# fetch_issue

Instruction fetch and issue stage feeding the control decoder. Fetches 16-bit instructions from instruction memory over a req/ack handshake, holds the current instruction in an issue register, and presents `opcode` and `multiDiv` to `control`. Stalls issue for a fixed interval after a multiply/divide, and accepts PC redirects from jump/branch resolution.

## Interface
- `ADDR_W`, 16, PC and instruction-memory address width.
- `MULDIV_CYCLES`, 4, issue-blocked cycles after a multiply/divide is consumed; legal range 1..15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imemReq`  out  1  fetch request; held high until `imemAck`.
- `imemAddr`  out  ADDR_W  fetch address (current PC); stable while `imemReq` is high, unless a redirect aborts the request.
- `imemAck`  in  1  data valid on `imemData` this cycle; ignored when `imemReq` is low.
- `imemData`  in  16  fetched instruction.
- `stall`  in  1  downstream cannot consume the issued instruction.
- `redirect`  in  1  jump/branch taken; one-cycle pulse.
- `redirectPc`  in  ADDR_W  target PC, sampled when `redirect` is high.
- `instrValid`  out  1  `instr`/`opcode`/`multiDiv` are valid.
- `instr`  out  16  issued instruction.
- `opcode`  out  4  `instr[15:12]`.
- `multiDiv`  out  1  high when `opcode` = 4'b1111 and `instr[3:0]` ∈ {4'b0100 mult, 4'b0101 div}.
- `pcOut`  out  ADDR_W  address of the issued instruction.

## Operation
- States: RST, FETCH, ISSUE, MDWAIT.
- RST: entered on reset. Next edge goes to FETCH.
- FETCH: `imemReq`=1, `imemAddr`=PC. On `imemAck`: latch `imemData` into `instr`, `pcOut`<=PC, PC<=PC+2 (mod 2^ADDR_W, wraps 0xFFFE→0x0000), `instrValid`<=1, go to ISSUE.
- ISSUE: `imemReq`=0. An instruction is consumed on an edge with `instrValid`=1 and `stall`=0. On consume, `instrValid`<=0. If `multiDiv` was set, load the counter with MULDIV_CYCLES and go to MDWAIT; otherwise go to FETCH. While `stall`=1, all outputs hold.
- MDWAIT: `imemReq`=0, `instrValid`=0. The counter decrements every cycle. At counter=1, go to FETCH.
- Redirect (any state except RST) has priority over all other events. PC<=`redirectPc`, `instrValid`<=0, counter<=0, next state FETCH. An `imemAck` in the same cycle is discarded. An outstanding request is aborted: the address changes next cycle and imem must tolerate this.
- `opcode` and `multiDiv` are combinational from `instr`. `multiDiv` is gated by `instrValid`.
- Reset mid-fetch or mid-MDWAIT: the asynchronous clear wins immediately and no ack is recorded.

## Timing
- Reset values: `imemReq`=0, `imemAddr`=0, PC=0, `instrValid`=0, `instr`=0, `opcode`=0, `multiDiv`=0, `pcOut`=0, counter=0, state RST.
- First `imemReq` is one cycle after `rst_n` deasserts.
- Fetch-to-issue latency: `instrValid` rises on the edge that samples `imemAck`. With zero-wait imem, peak throughput is one instruction per 2 cycles.
- After a multiply/divide is consumed, `imemReq` rises exactly MULDIV_CYCLES+1 cycles later: MULDIV_CYCLES in MDWAIT plus one edge into FETCH.
- Redirect-to-request latency: `imemReq`=1 with `imemAddr`=`redirectPc` on the cycle after `redirect`.

## Configuration
- `MULDIV_STALL_EN` defined: MDWAIT and its counter are present, with behaviour as above.
- `MULDIV_STALL_EN` undefined: no MDWAIT state and no counter. A consumed `multiDiv` instruction goes straight to FETCH like any other. `multiDiv` output is still produced.

## Structure
- Shared include `cpu_defs.vh` holds:
  - opcode constants (TYPE_A = 4'b1111, etc.)
  - funct codes FN_MULT = 4'b0100 and FN_DIV = 4'b0101
  - state encodings for fetch_issue
- One sub-module, `muldiv_stall_counter`: loadable down-counter with a `done` output, instantiated only under `MULDIV_STALL_EN`.

## Test plan
- Reset release, imem acks every request immediately, instructions 0x1234/0x2000 → `imemAddr` 0x0000 then 0x0002; `opcode` 4'b0001 then 4'b0010; `instrValid` high every second cycle.
- `stall`=1 for 3 cycles while holding 0xA005 → `instr`, `pcOut` and `instrValid` unchanged; `imemReq`=0 until the cycle after `stall` drops.
- Issue 0xF004 (mult) with MULDIV_CYCLES=4 → `multiDiv`=1; after consume, `imemReq` stays low for 4 cycles and rises on the 5th. Without `MULDIV_STALL_EN`, it rises on the next cycle.
- `redirect`=1 with `redirectPc`=0x0040 in the same cycle as `imemAck` → that data is dropped, `instrValid` stays 0, and the next `imemAddr` is 0x0040.
- PC at 0xFFFE acked → next `imemAddr` is 0x0000.
- `rst_n` pulsed low during MDWAIT → all outputs return to reset values immediately; `imemReq` rises 1 cycle after release.

Source files
------------

// File: rtl/fetch_issue_pkg.sv
// Shared definitions for the fetch/issue stage.
//   - Opcode and funct constants used to classify issued instructions.
//   - State encoding of the fetch/issue controller.
//   - is_muldiv(): classifies an instruction as multiply or divide.
package fetch_issue_pkg;

  localparam int unsigned InstrW = 16;

  // Opcodes (instr[15:12])
  localparam logic [3:0] OpTypeA = 4'b1111;

  // Function codes for OpTypeA (instr[3:0])
  localparam logic [3:0] FnMult = 4'b0100;
  localparam logic [3:0] FnDiv  = 4'b0101;

  typedef enum logic [1:0] {
    StRst    = 2'd0,
    StFetch  = 2'd1,
    StIssue  = 2'd2,
    StMdWait = 2'd3
  } fetch_state_e;

  function automatic logic is_muldiv(input logic [InstrW-1:0] instr);
    return (instr[15:12] == OpTypeA) && ((instr[3:0] == FnMult) || (instr[3:0] == FnDiv));
  endfunction

endpackage

// File: rtl/muldiv_stall_counter.sv
// Loadable down-counter that times the issue blackout after a multiply/divide.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   clear_i        - force the count to zero (highest priority)
//   load_i         - load load_val_i
//   load_val_i     - value loaded on load_i
//   dec_i          - decrement by one (saturates at zero)
//   done_o         - count is 1, i.e. the current cycle is the last wait cycle
module muldiv_stall_counter #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/fetch_issue.sv
// Instruction fetch and issue stage.
// Fetches 16-bit instructions over a req/ack handshake, holds the current one in an issue
// register and presents opcode/multi_div to the control decoder. Accepts PC redirects from
// jump/branch resolution, which take priority over everything except reset.
//
// Build option: define MULDIV_STALL_EN to block issue for MuldivCycles cycles after a
// multiply/divide is consumed (adds the MDWAIT state and muldiv_stall_counter).
//
// Ports:
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   imem_req_o       - fetch request, held until imem_ack_i
//   imem_addr_o      - fetch address (current PC)
//   imem_ack_i       - imem_data_i valid this cycle (ignored without a request)
//   imem_data_i      - fetched instruction
//   stall_i          - downstream cannot consume the issued instruction
//   redirect_i       - one-cycle jump/branch taken pulse
//   redirect_pc_i    - redirect target PC
//   instr_valid_o    - instr_o/opcode_o/multi_div_o are valid
//   instr_o          - issued instruction
//   opcode_o         - instr_o[15:12]
//   multi_div_o      - issued instruction is a multiply or divide
//   pc_o             - address of the issued instruction
module fetch_issue
  import fetch_issue_pkg::*;
#(
  parameter int unsigned AddrW        = 16,
  parameter int unsigned MuldivCycles = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [AddrW-1:0]  imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [InstrW-1:0] imem_data_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [AddrW-1:0]  redirect_pc_i,
  output logic              instr_valid_o,
  output logic [InstrW-1:0] instr_o,
  output logic [3:0]        opcode_o,
  output logic              multi_div_o,
  output logic [AddrW-1:0]  pc_o
);

  if ((MuldivCycles == 0) || (MuldivCycles > 15)) begin : g_bad_muldiv_cycles
    $error("MuldivCycles must be in 1..15");
  end

  fetch_state_e      state_q, state_d;
  logic [AddrW-1:0]  pc_q, pc_d;
  logic [AddrW-1:0]  pc_out_q, pc_out_d;
  logic [InstrW-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              consume;

`ifdef MULDIV_STALL_EN
  logic md_load, md_clear, md_dec, md_done;

  assign md_dec = (state_q == StMdWait);

  muldiv_stall_counter #(
    .CntW (4)
  ) u_muldiv_stall_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (md_clear),
    .load_i     (md_load),
    .load_val_i (4'(MuldivCycles)),
    .dec_i      (md_dec),
    .done_o     (md_done)
  );
`endif

  assign consume = (state_q == StIssue) && valid_q && !stall_i;

  // State register and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StRst;
      pc_q     <= '0;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
`ifdef MULDIV_STALL_EN
    md_load  = 1'b0;
    md_clear = 1'b0;
`endif

    if (redirect_i && (state_q != StRst)) begin
      // Redirect wins: a same-cycle ack is dropped and any outstanding request is abandoned.
      pc_d    = redirect_pc_i;
      valid_d = 1'b0;
      state_d = StFetch;
`ifdef MULDIV_STALL_EN
      md_clear = 1'b1;
`endif
    end else begin
      unique case (state_q)
        StRst: begin
          state_d = StFetch;
        end
        StFetch: begin
          if (imem_ack_i) begin
            instr_d  = imem_data_i;
            pc_out_d = pc_q;
            pc_d     = pc_q + AddrW'(2);
            valid_d  = 1'b1;
            state_d  = StIssue;
          end
        end
        StIssue: begin
          if (consume) begin
            valid_d = 1'b0;
            state_d = StFetch;
`ifdef MULDIV_STALL_EN
            if (multi_div_o) begin
              md_load = 1'b1;
              state_d = StMdWait;
            end
`endif
          end
        end
        StMdWait: begin
`ifdef MULDIV_STALL_EN
          if (md_done) begin
            state_d = StFetch;
          end
`else
          state_d = StFetch;
`endif
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // Outputs
  always_comb begin
    imem_req_o    = (state_q == StFetch);
    imem_addr_o   = pc_q;
    instr_valid_o = valid_q;
    instr_o       = instr_q;
    opcode_o      = instr_q[15:12];
    multi_div_o   = valid_q && is_muldiv(instr_q);
    pc_o          = pc_out_q;
  end

endmodule

// File: tb/tb_fetch_issue.sv
// Self-checking bench for fetch_issue: directed scenarios plus a randomized run checked
// against a transaction-level model of the fetch/issue rules.
module tb_fetch_issue;

  localparam int MdC = 4;
`ifdef MULDIV_STALL_EN
  localparam int MdLow = MdC;
`else
  localparam int MdLow = 0;
`endif

  logic        clk, rst_n;
  logic        imem_req, imem_ack, stall, redirect;
  logic [15:0] imem_addr, imem_data, redirect_pc, instr, pc_o;
  logic        instr_valid, multi_div;
  logic [3:0]  opcode;

  int tests = 0;
  int fails = 0;

  fetch_issue #(
    .AddrW        (16),
    .MuldivCycles (MdC)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_data_i   (imem_data),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .opcode_o      (opcode),
    .multi_div_o   (multi_div),
    .pc_o          (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_md(input logic [15:0] x);
    return (x[15:12] == 4'hF) && ((x[3:0] == 4'h4) || (x[3:0] == 4'h5));
  endfunction

  // Leaves the DUT in its first fetch (addr 0) at a falling edge, inputs idle.
  task automatic apply_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b1; imem_data = 16'hFFFF; stall = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h1234;
    @(negedge clk); @(negedge clk);
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || multi_div !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: req=%b valid=%b md=%b want 0 0 0", imem_req, instr_valid, multi_div);
    end
    tests++;
    if (imem_addr !== 16'h0 || pc_o !== 16'h0) begin
      fails++; $display("FAIL reset_addr: addr=%h pc=%h want 0000 0000", imem_addr, pc_o);
    end
    tests++;
    if (instr !== 16'h0 || opcode !== 4'h0) begin
      fails++; $display("FAIL reset_instr: instr=%h opcode=%h want 0000 0", instr, opcode);
    end
    imem_ack = 1'b0; redirect = 1'b0; rst_n = 1'b1;
    #1;
    tests++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL reset_release_req: got %b want 0", imem_req);
    end
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
      fails++; $display("FAIL first_req: req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    imem_ack = 1'b1; imem_data = 16'h1234;
    @(negedge clk);
    imem_ack = 1'b0;
    tests++;
    if (instr_valid !== 1'b1 || instr !== 16'h1234 || opcode !== 4'h1 || pc_o !== 16'h0
        || imem_req !== 1'b0) begin
      fails++;
      $display("FAIL basic_issue0: valid=%b instr=%h op=%h pc=%h req=%b want 1 1234 1 0000 0",
               instr_valid, instr, opcode, pc_o, imem_req);
    end
    @(negedge clk);
    tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
      fails++;
      $display("FAIL basic_fetch1: valid=%b req=%b addr=%h want 0 1 0002",
               instr_valid, imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_data = 16'h2000;
    @(negedge clk);
    imem_ack = 1'b0;
    tests++;
    if (instr_valid !== 1'b1 || opcode !== 4'h2 || pc_o !== 16'h0002 || multi_div !== 1'b0) begin
      fails++;
      $display("FAIL basic_issue1: valid=%b op=%h pc=%h md=%b want 1 2 0002 0",
               instr_valid, opcode, pc_o, multi_div);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    imem_ack = 1'b1; imem_data = 16'hA005;
    @(negedge clk);
    imem_ack = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (instr_valid !== 1'b1 || instr !== 16'hA005 || pc_o !== 16'h0 || imem_req !== 1'b0
          || multi_div !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h req=%b md=%b want 1 a005 0000 0 0",
                 i, instr_valid, instr, pc_o, imem_req, multi_div);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b want 1 0002 0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_muldiv();
    logic [15:0] seq [3] = '{16'hF004, 16'hF005, 16'hF006};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      imem_ack = 1'b1; imem_data = seq[k];
      @(negedge clk);
      imem_ack = 1'b0;
      tests++;
      if (instr_valid !== 1'b1 || opcode !== 4'hF || multi_div !== ref_md(seq[k])) begin
        fails++;
        $display("FAIL muldiv_flag[%0d]: valid=%b op=%h md=%b want 1 f %b",
                 k, instr_valid, opcode, multi_div, ref_md(seq[k]));
      end
      for (int i = 0; i < (ref_md(seq[k]) ? MdLow : 0); i++) begin
        @(negedge clk);
        tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || multi_div !== 1'b0) begin
          fails++;
          $display("FAIL muldiv_wait[%0d.%0d]: req=%b valid=%b md=%b want 0 0 0",
                   k, i, imem_req, instr_valid, multi_div);
        end
      end
      @(negedge clk);
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(2 * (k + 1))) begin
        fails++;
        $display("FAIL muldiv_refetch[%0d]: req=%b addr=%h want 1 %h",
                 k, imem_req, imem_addr, 16'(2 * (k + 1)));
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    imem_ack = 1'b1; imem_data = 16'h1111; redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    imem_ack = 1'b0; redirect = 1'b0;
    tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      fails++;
      $display("FAIL redirect_ack_drop: valid=%b req=%b addr=%h want 0 1 0040",
               instr_valid, imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_data = 16'h2222;
    @(negedge clk);
    imem_ack = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0;
    tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
      fails++;
      $display("FAIL redirect_issue: valid=%b req=%b addr=%h want 0 1 0080",
               instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect = 1'b0; imem_ack = 1'b1; imem_data = 16'h3333;
    @(negedge clk);
    imem_ack = 1'b0;
    tests++;
    if (pc_o !== 16'hFFFE || instr !== 16'h3333) begin
      fails++; $display("FAIL wrap_issue: pc=%h instr=%h want fffe 3333", pc_o, instr);
    end
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      fails++; $display("FAIL wrap_addr: req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mdwait();
    apply_reset();
    imem_ack = 1'b1; imem_data = 16'hF005;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0 || instr_valid !== 1'b0 || instr !== 16'h0
        || opcode !== 4'h0 || multi_div !== 1'b0 || pc_o !== 16'h0) begin
      fails++;
      $display("FAIL reset_mdwait: req=%b addr=%h valid=%b instr=%h md=%b pc=%h want all 0",
               imem_req, imem_addr, instr_valid, instr, multi_div, pc_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL reset_mdwait_release: req=%b want 0", imem_req);
    end
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
      fails++; $display("FAIL reset_mdwait_req: req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
  endtask

  // Model: a request is outstanding whenever nothing is held and no mul/div blackout runs.
  task automatic test_random();
    logic [15:0] exp_pc, exp_instr, exp_pcout, d, tgt;
    logic        exp_valid, exp_req, rd, ak, st;
    int          quiet;
    apply_reset();
    exp_pc = '0; exp_instr = '0; exp_pcout = '0; exp_valid = 1'b0; quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      exp_req = !exp_valid && (quiet == 0);
      tests++;
      if (instr_valid !== exp_valid || imem_req !== exp_req) begin
        fails++;
        $display("FAIL rand_ctrl c=%0d: valid=%b req=%b want %b %b",
                 c, instr_valid, imem_req, exp_valid, exp_req);
      end
      if (exp_req) begin
        tests++;
        if (imem_addr !== exp_pc) begin
          fails++; $display("FAIL rand_addr c=%0d: addr=%h want %h", c, imem_addr, exp_pc);
        end
      end
      tests++;
      if (exp_valid && (instr !== exp_instr || pc_o !== exp_pcout
          || opcode !== exp_instr[15:12] || multi_div !== ref_md(exp_instr))) begin
        fails++;
        $display("FAIL rand_issue c=%0d: instr=%h pc=%h op=%h md=%b want %h %h %h %b", c, instr,
                 pc_o, opcode, multi_div, exp_instr, exp_pcout, exp_instr[15:12], ref_md(exp_instr));
      end else if (!exp_valid && multi_div !== 1'b0) begin
        fails++; $display("FAIL rand_md_gate c=%0d: md=%b want 0", c, multi_div);
      end

      rd  = ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFC : (16'($urandom_range(0, 32767)) << 1);
      ak  = ($urandom_range(0, 2) != 0);
      st  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       d = {4'hF, 8'($urandom), 4'h4};
        1:       d = {4'hF, 8'($urandom), 4'h5};
        default: d = 16'($urandom);
      endcase
      redirect = rd; redirect_pc = tgt; imem_ack = ak; imem_data = d; stall = st;

      if (rd) begin
        exp_pc = tgt; exp_valid = 1'b0; quiet = 0;
      end else if (exp_req && ak) begin
        exp_valid = 1'b1; exp_instr = d; exp_pcout = exp_pc; exp_pc = exp_pc + 16'd2;
      end else if (exp_valid && !st) begin
        exp_valid = 1'b0; quiet = ref_md(exp_instr) ? MdLow : 0;
      end else if (quiet > 0) begin
        quiet--;
      end
      @(negedge clk);
    end
    redirect = 1'b0; imem_ack = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_muldiv();
    test_redirect();
    test_wrap();
    test_reset_mdwait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
